carry_resolve_stream: RTL and testbench



---
 rtl/carry_pkg.sv | 33 +++
 rtl/carry_byte_out_reg.sv | 78 +++++++
 rtl/carry_resolve_stream.sv | 279 +++++++++++++++++++++++++++
 tb/tb_carry_resolve_stream.sv | 493 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/carry_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : carry_pkg
//  Description : Shared definitions for the streaming carry-resolution stage:
//                FSM state encoding, default byte width, fill selectors and
//                the precarry word width derivation.
//  Revision    : 1.0 - initial release
// ============================================================================
package carry_pkg;

   localparam int BYTE_WIDTH_DEF = 8;

   // Precarry word = one data byte plus a carry bit in the MSB.
   function automatic int pc_width(input int byte_width);
      return byte_width + 1;
   endfunction

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE       = 3'd0;
   localparam state_t ST_LANE       = 3'd1;
   localparam state_t ST_RUN        = 3'd2;
   localparam state_t ST_FLUSH_PREV = 3'd3;
   localparam state_t ST_FLUSH_RUN  = 3'd4;
   localparam state_t ST_DONE       = 3'd5;

   // Fill byte is stored as a single select bit and replicated to byte width:
   // a resolved carry turns the pending 0xFF run into zeros.
   localparam logic FILL_ZERO = 1'b0;
   localparam logic FILL_ONES = 1'b1;

endpackage
`default_nettype wire

// File: rtl/carry_byte_out_reg.sv
`default_nettype none
// ============================================================================
//  Module      : carry_byte_out_reg
//  Description : Output holding register with valid/ready handshake, last
//                marker and a handshake counter.
//  Ports       : clk, rst_n       - clock, async active-low reset
//                emit_*           - byte to load (only when slot_free)
//                count_clear      - restart the handshake counter
//                out_ready        - sink ready
//                out_valid/byte/last/count - registered output side
//                slot_free        - register may be loaded this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module carry_byte_out_reg #(
   parameter int BYTE_WIDTH  = 8,
   parameter int COUNT_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   emit_valid,
   input  logic [BYTE_WIDTH-1:0]  emit_byte,
   input  logic                   emit_last,
   input  logic                   count_clear,
   input  logic                   out_ready,
   output logic                   out_valid,
   output logic [BYTE_WIDTH-1:0]  out_byte,
   output logic                   out_last,
   output logic [COUNT_WIDTH-1:0] out_count,
   output logic                   slot_free
);

   logic                   valid_q, valid_d;
   logic [BYTE_WIDTH-1:0]  byte_q,  byte_d;
   logic                   last_q,  last_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;
   logic                   hs;

   assign hs        = valid_q & out_ready;
   assign slot_free = ~valid_q | out_ready;

   always_comb begin
      valid_d = valid_q;
      byte_d  = byte_q;
      last_d  = last_q;
      count_d = count_clear ? '0 : count_q;
      if (hs) begin
         valid_d = 1'b0;
         count_d = count_d + COUNT_WIDTH'(1);
      end
      // Byte and last only change on a load, so they hold while stalled.
      if (emit_valid) begin
         valid_d = 1'b1;
         byte_d  = emit_byte;
         last_d  = emit_last;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         byte_q  <= '0;
         last_q  <= 1'b0;
         count_q <= '0;
      end else begin
         valid_q <= valid_d;
         byte_q  <= byte_d;
         last_q  <= last_d;
         count_q <= count_d;
      end
   end

   assign out_valid = valid_q;
   assign out_byte  = byte_q;
   assign out_last  = last_q;
   assign out_count = count_q;

endmodule
`default_nettype wire

// File: rtl/carry_resolve_stream.sv
`default_nettype none
// ============================================================================
//  Module      : carry_resolve_stream
//  Description : Streaming carry resolution for the arithmetic encoder back
//                end. Bundles of precarry words are resolved with a pending
//                byte plus a run counter of 0xFF bytes and emitted one byte
//                per cycle; end of stream flushes the pending state.
//  Ports       : s4_clk, s4_reset_n           - clock, async active-low reset
//                s4_in_valid/ready/words/count/last - input bundle handshake
//                s4_out_valid/ready/byte/last  - output byte handshake
//                s4_out_count                 - bytes handshaken this stream
//                s4_done                      - end-of-stream pulse
//                s4_err_*                     - sticky stream error flags
//  Revision    : 1.0 - initial release
// ============================================================================
module carry_resolve_stream
   import carry_pkg::*;
#(
   parameter int BYTE_WIDTH  = BYTE_WIDTH_DEF,
   parameter int IN_LANES    = 4,
   parameter int RUN_WIDTH   = 8,
   parameter int COUNT_WIDTH = 32
) (
   input  logic                                  s4_clk,
   input  logic                                  s4_reset_n,
   input  logic                                  s4_in_valid,
   output logic                                  s4_in_ready,
   input  logic [IN_LANES*(BYTE_WIDTH+1)-1:0]    s4_in_words,
   input  logic [$clog2(IN_LANES+1)-1:0]         s4_in_count,
   input  logic                                  s4_in_last,
   output logic                                  s4_out_valid,
   input  logic                                  s4_out_ready,
   output logic [BYTE_WIDTH-1:0]                 s4_out_byte,
   output logic                                  s4_out_last,
   output logic [COUNT_WIDTH-1:0]                s4_out_count,
   output logic                                  s4_done,
   output logic                                  s4_err_carry_first,
   output logic                                  s4_err_run_overflow,
   output logic                                  s4_err_carry_wrap
);

   localparam int PC_WIDTH = pc_width(BYTE_WIDTH);
   localparam int CNT_W    = $clog2(IN_LANES + 1);
   localparam int LANE_W   = (IN_LANES > 1) ? $clog2(IN_LANES) : 1;

   state_t                         state_q, state_d;
   logic [IN_LANES*PC_WIDTH-1:0]   words_q, words_d;
   logic [CNT_W-1:0]               count_q, count_d;
   logic                           blast_q, blast_d;
   logic [LANE_W-1:0]              lane_q, lane_d;
   logic [BYTE_WIDTH-1:0]          prev_q, prev_d;
   logic                           prev_valid_q, prev_valid_d;
   logic [RUN_WIDTH-1:0]           run_q, run_d;
   logic                           fill_q, fill_d;
   logic                           err_cf_q, err_cf_d;
   logic                           err_ov_q, err_ov_d;
   logic                           err_wrap_q, err_wrap_d;
   logic                           closed_q, closed_d;

   logic [PC_WIDTH-1:0]            lane_word [IN_LANES];
   logic [PC_WIDTH-1:0]            cur_word;
   logic                           cur_c;
   logic [BYTE_WIDTH-1:0]          cur_b;
   logic [BYTE_WIDTH:0]            sum;
   logic [CNT_W-1:0]               lane_ext;
   logic                           lane_final;
   logic                           advance;

   logic                           emit_valid;
   logic [BYTE_WIDTH-1:0]          emit_byte;
   logic                           emit_last;
   logic                           count_clear;
   logic                           slot_free;

   for (genvar g = 0; g < IN_LANES; g++) begin : g_lane_unpack
      assign lane_word[g] = words_q[g*PC_WIDTH +: PC_WIDTH];
   end

   assign cur_word   = lane_word[lane_q];
   assign cur_c      = cur_word[PC_WIDTH-1];
   assign cur_b      = cur_word[BYTE_WIDTH-1:0];
   assign sum        = {1'b0, prev_q} + {{BYTE_WIDTH{1'b0}}, cur_c};
   assign lane_ext   = CNT_W'(lane_q);
   assign lane_final = (lane_ext == (count_q - CNT_W'(1)));

   // State register
   always_ff @(posedge s4_clk or negedge s4_reset_n) begin
      if (!s4_reset_n) begin
         state_q      <= ST_IDLE;
         words_q      <= '0;
         count_q      <= '0;
         blast_q      <= 1'b0;
         lane_q       <= '0;
         prev_q       <= '0;
         prev_valid_q <= 1'b0;
         run_q        <= '0;
         fill_q       <= FILL_ONES;
         err_cf_q     <= 1'b0;
         err_ov_q     <= 1'b0;
         err_wrap_q   <= 1'b0;
         closed_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         words_q      <= words_d;
         count_q      <= count_d;
         blast_q      <= blast_d;
         lane_q       <= lane_d;
         prev_q       <= prev_d;
         prev_valid_q <= prev_valid_d;
         run_q        <= run_d;
         fill_q       <= fill_d;
         err_cf_q     <= err_cf_d;
         err_ov_q     <= err_ov_d;
         err_wrap_q   <= err_wrap_d;
         closed_q     <= closed_d;
      end
   end

   // Next-state and datapath
   always_comb begin
      state_d      = state_q;
      words_d      = words_q;
      count_d      = count_q;
      blast_d      = blast_q;
      lane_d       = lane_q;
      prev_d       = prev_q;
      prev_valid_d = prev_valid_q;
      run_d        = run_q;
      fill_d       = fill_q;
      err_cf_d     = err_cf_q;
      err_ov_d     = err_ov_q;
      err_wrap_d   = err_wrap_q;
      closed_d     = closed_q;
      emit_valid   = 1'b0;
      emit_byte    = prev_q;
      emit_last    = 1'b0;
      count_clear  = 1'b0;
      advance      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (s4_in_valid) begin
               words_d     = s4_in_words;
               count_d     = s4_in_count;
               blast_d     = s4_in_last;
               lane_d      = '0;
               // First bundle of a new stream restarts the byte counter.
               count_clear = closed_q;
               closed_d    = 1'b0;
               if (s4_in_count == '0) begin
                  state_d = s4_in_last ? ST_FLUSH_PREV : ST_IDLE;
               end else begin
                  state_d = ST_LANE;
               end
            end
         end

         ST_LANE: begin
            if (!cur_c && (cur_b == '1) && prev_valid_q) begin
               // Could still be carried into: just count it.
               if (run_q == '1) begin
                  err_ov_d = 1'b1;
               end else begin
                  run_d = run_q + RUN_WIDTH'(1);
               end
               advance = 1'b1;
            end else if (!prev_valid_q) begin
               prev_d       = cur_b;
               prev_valid_d = 1'b1;
               if (cur_c) begin
                  err_cf_d = 1'b1;
               end
               advance = 1'b1;
            end else if (slot_free) begin
               emit_valid = 1'b1;
               emit_byte  = sum[BYTE_WIDTH-1:0];
               if (sum[BYTE_WIDTH]) begin
                  err_wrap_d = 1'b1;
               end
               prev_d = cur_b;
               fill_d = cur_c ? FILL_ZERO : FILL_ONES;
               if (run_q != '0) begin
                  state_d = ST_RUN;
               end else begin
                  advance = 1'b1;
               end
            end
         end

         ST_RUN: begin
            if (slot_free) begin
               emit_valid = 1'b1;
               emit_byte  = {BYTE_WIDTH{fill_q}};
               run_d      = run_q - RUN_WIDTH'(1);
               if (run_q == RUN_WIDTH'(1)) begin
                  advance = 1'b1;
               end
            end
         end

         ST_FLUSH_PREV: begin
            if (!prev_valid_q) begin
               // Nothing was ever produced in this stream.
               state_d = ST_DONE;
            end else if (slot_free) begin
               emit_valid   = 1'b1;
               emit_byte    = prev_q;
               emit_last    = (run_q == '0);
               prev_valid_d = 1'b0;
               state_d      = ST_FLUSH_RUN;
            end
         end

         ST_FLUSH_RUN: begin
            if (run_q != '0) begin
               if (slot_free) begin
                  emit_valid = 1'b1;
                  emit_byte  = {BYTE_WIDTH{FILL_ONES}};
                  emit_last  = (run_q == RUN_WIDTH'(1));
                  run_d      = run_q - RUN_WIDTH'(1);
               end
            end else if (!s4_out_valid || s4_out_ready) begin
               // Final byte is being (or has been) taken by the sink.
               state_d = ST_DONE;
            end
         end

         ST_DONE: begin
            prev_valid_d = 1'b0;
            run_d        = '0;
            closed_d     = 1'b1;
            state_d      = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (advance) begin
         if (lane_final) begin
            state_d = blast_q ? ST_FLUSH_PREV : ST_IDLE;
         end else begin
            lane_d  = lane_q + LANE_W'(1);
            state_d = ST_LANE;
         end
      end
   end

   // Outputs
   always_comb begin
      s4_in_ready = (state_q == ST_IDLE) & s4_reset_n;
      s4_done     = (state_q == ST_DONE);
   end

   assign s4_err_carry_first  = err_cf_q;
   assign s4_err_run_overflow = err_ov_q;
   assign s4_err_carry_wrap   = err_wrap_q;

   carry_byte_out_reg #(
      .BYTE_WIDTH  (BYTE_WIDTH),
      .COUNT_WIDTH (COUNT_WIDTH)
   ) u_out_reg (
      .clk         (s4_clk),
      .rst_n       (s4_reset_n),
      .emit_valid  (emit_valid),
      .emit_byte   (emit_byte),
      .emit_last   (emit_last),
      .count_clear (count_clear),
      .out_ready   (s4_out_ready),
      .out_valid   (s4_out_valid),
      .out_byte    (s4_out_byte),
      .out_last    (s4_out_last),
      .out_count   (s4_out_count),
      .slot_free   (slot_free)
   );

endmodule
`default_nettype wire

// File: tb/tb_carry_resolve_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_carry_resolve_stream
//  Description : Self-checking bench for carry_resolve_stream (RUN_WIDTH=2).
//                Directed scenarios plus random streams against a digit-array
//                reference model of the carry resolution rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_carry_resolve_stream;

   localparam int BW      = 8;
   localparam int LANES   = 4;
   localparam int RW      = 2;
   localparam int CW      = 32;
   localparam int PCW     = BW + 1;
   localparam int INW     = LANES * PCW;
   localparam int CNTW    = $clog2(LANES + 1);
   localparam int RUN_MAX = (1 << RW) - 1;

   logic            s4_clk = 1'b0;
   logic            s4_reset_n = 1'b0;
   logic            s4_in_valid = 1'b0;
   logic            s4_in_ready;
   logic [INW-1:0]  s4_in_words = '0;
   logic [CNTW-1:0] s4_in_count = '0;
   logic            s4_in_last = 1'b0;
   logic            s4_out_valid;
   logic            s4_out_ready = 1'b0;
   logic [BW-1:0]   s4_out_byte;
   logic            s4_out_last;
   logic [CW-1:0]   s4_out_count;
   logic            s4_done;
   logic            s4_err_carry_first;
   logic            s4_err_run_overflow;
   logic            s4_err_carry_wrap;

   int vectors = 0;
   int miscompares = 0;
   bit bp_mode = 1'b0;

   carry_resolve_stream #(
      .BYTE_WIDTH (BW),
      .IN_LANES   (LANES),
      .RUN_WIDTH  (RW),
      .COUNT_WIDTH(CW)
   ) dut (
      .s4_clk              (s4_clk),
      .s4_reset_n          (s4_reset_n),
      .s4_in_valid         (s4_in_valid),
      .s4_in_ready         (s4_in_ready),
      .s4_in_words         (s4_in_words),
      .s4_in_count         (s4_in_count),
      .s4_in_last          (s4_in_last),
      .s4_out_valid        (s4_out_valid),
      .s4_out_ready        (s4_out_ready),
      .s4_out_byte         (s4_out_byte),
      .s4_out_last         (s4_out_last),
      .s4_out_count        (s4_out_count),
      .s4_done             (s4_done),
      .s4_err_carry_first  (s4_err_carry_first),
      .s4_err_run_overflow (s4_err_run_overflow),
      .s4_err_carry_wrap   (s4_err_carry_wrap)
   );

   always #5 s4_clk = ~s4_clk;

   initial begin
      forever begin
         @(posedge s4_clk);
         #1;
         if (bp_mode) s4_out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // ---------------- output monitor (samples on falling edge) ----------------
   int        got_bytes[$];
   bit        got_last[$];
   int        cyc = 0;
   int        last_cyc = -1;
   int        done_cyc = -1;
   int        done_pulses = 0;
   int        done_count = 0;
   int        hold_viol = 0;
   bit        prev_stall = 1'b0;
   logic [BW-1:0] prev_byte = '0;
   logic      prev_last = 1'b0;

   always @(negedge s4_clk) begin
      cyc = cyc + 1;
      if (prev_stall && s4_out_valid &&
          (s4_out_byte !== prev_byte || s4_out_last !== prev_last))
         hold_viol = hold_viol + 1;
      prev_stall = s4_out_valid && !s4_out_ready && s4_reset_n;
      prev_byte  = s4_out_byte;
      prev_last  = s4_out_last;
      if (s4_out_valid && s4_out_ready) begin
         got_bytes.push_back(int'(s4_out_byte));
         got_last.push_back(s4_out_last);
         if (s4_out_last) last_cyc = cyc;
      end
      if (s4_done) begin
         done_pulses = done_pulses + 1;
         done_cyc    = cyc;
         done_count  = int'(s4_out_count);
      end
   end

   // ---------------- stimulus plumbing + reference model ----------------
   logic [INW-1:0] bq_words[$];
   int             bq_count[$];
   logic [PCW-1:0] stream_words[$];
   int             exp_bytes[$];
   bit             m_cf = 1'b0, m_ov = 1'b0, m_wrap = 1'b0;

   function automatic void clear_mon();
      got_bytes.delete();
      got_last.delete();
      last_cyc    = -1;
      done_cyc    = -1;
      done_pulses = 0;
      hold_viol   = 0;
   endfunction

   function automatic void add_bundle(input logic [PCW-1:0] w0, input logic [PCW-1:0] w1,
                                      input logic [PCW-1:0] w2, input logic [PCW-1:0] w3,
                                      input int cnt);
      bq_words.push_back({w3, w2, w1, w0});
      bq_count.push_back(cnt);
   endfunction

   // Bitstream as a digit array: a carry ripples back through the trailing
   // 0xFF digits into the anchor digit (last non-run digit) and stops there.
   function automatic void model_stream();
      int digits[$];
      int p;
      int c;
      int b;
      p = -1;
      foreach (stream_words[i]) begin
         c = int'(stream_words[i][PCW-1]);
         b = int'(stream_words[i][BW-1:0]);
         if (p < 0) begin
            digits.push_back(b);
            p = digits.size() - 1;
            if (c != 0) m_cf = 1'b1;
         end else if (c == 0 && b == 255) begin
            if (digits.size() - 1 - p >= RUN_MAX) m_ov = 1'b1;
            else digits.push_back(255);
         end else begin
            if (c != 0) begin
               for (int k = p + 1; k < digits.size(); k++) digits[k] = 0;
               if (digits[p] == 255) m_wrap = 1'b1;
               digits[p] = (digits[p] + 1) % 256;
            end
            digits.push_back(b);
            p = digits.size() - 1;
         end
      end
      exp_bytes = digits;
   endfunction

   function automatic logic [PCW-1:0] rand_word();
      int r;
      r = $urandom_range(0, 9);
      if (r < 4) return 9'h0FF;
      if (r < 7) return {1'b0, 8'($urandom)};
      if (r < 9) return {1'b1, 8'($urandom)};
      return 9'h1FF;
   endfunction

   task automatic send_bundle(input logic [INW-1:0] w, input int cnt, input bit lst);
      int t;
      t = 0;
      s4_in_words = w;
      s4_in_count = CNTW'(cnt);
      s4_in_last  = lst;
      s4_in_valid = 1'b1;
      forever begin
         @(negedge s4_clk);
         if (s4_in_ready) break;
         t++;
         if (t > 2000) begin
            vectors++;
            miscompares++;
            $display("FAIL in_ready_timeout: in_ready=%0b after %0d cycles, required 1", s4_in_ready, t);
            break;
         end
      end
      @(posedge s4_clk);
      #1;
      s4_in_valid = 1'b0;
   endtask

   task automatic run_stream();
      int t;
      logic [INW-1:0] w;
      clear_mon();
      stream_words.delete();
      foreach (bq_words[i]) begin
         w = bq_words[i];
         for (int k = 0; k < bq_count[i]; k++) stream_words.push_back(w[k*PCW +: PCW]);
      end
      model_stream();
      foreach (bq_words[i]) send_bundle(bq_words[i], bq_count[i], (i == bq_words.size() - 1));
      t = 0;
      while (done_pulses == 0 && t < 3000) begin
         @(posedge s4_clk);
         t++;
      end
      if (done_pulses == 0) begin
         vectors++;
         miscompares++;
         $display("FAIL done_timeout: done pulses=%0d, required 1", done_pulses);
      end
      repeat (2) @(posedge s4_clk);
      #1;
      bq_words.delete();
      bq_count.delete();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      s4_reset_n = 1'b0;
      repeat (3) @(negedge s4_clk);
      vectors++;
      if ({s4_out_valid, s4_out_last, s4_done, s4_in_ready} !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_ctrl: valid/last/done/in_ready=%b, required 0000",
                  {s4_out_valid, s4_out_last, s4_done, s4_in_ready});
      end
      vectors++;
      if (s4_out_byte !== 8'h00 || s4_out_count !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_data: byte=%h count=%0d, required 00 and 0", s4_out_byte, s4_out_count);
      end
      vectors++;
      if ({s4_err_carry_first, s4_err_run_overflow, s4_err_carry_wrap} !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_errs: errs=%b, required 000",
                  {s4_err_carry_first, s4_err_run_overflow, s4_err_carry_wrap});
      end
      @(posedge s4_clk);
      #1;
      s4_reset_n = 1'b1;
      m_cf = 0; m_ov = 0; m_wrap = 0;
      @(negedge s4_clk);
      vectors++;
      if (s4_in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_release_ready: in_ready=%b, required 1", s4_in_ready);
      end
      @(posedge s4_clk);
      #1;
   endtask

   task automatic test_patterns();
      logic [INW-1:0] pw[3];
      int pc[3];
      int pe[3][4];
      int nl;
      int lp;
      pw[0] = {9'h000, 9'h056, 9'h034, 9'h012}; pc[0] = 3; pe[0] = '{8'h12, 8'h34, 8'h56, 0};
      pw[1] = {9'h134, 9'h0FF, 9'h0FF, 9'h012}; pc[1] = 4; pe[1] = '{8'h13, 8'h00, 8'h00, 8'h34};
      pw[2] = {9'h000, 9'h0FF, 9'h0FF, 9'h020}; pc[2] = 3; pe[2] = '{8'h20, 8'hFF, 8'hFF, 0};
      s4_out_ready = 1'b1;
      for (int p = 0; p < 3; p++) begin
         bq_words.push_back(pw[p]);
         bq_count.push_back(pc[p]);
         run_stream();
         vectors++;
         if (got_bytes.size() != pc[p]) begin
            miscompares++;
            $display("FAIL pat%0d_len: got %0d bytes, required %0d", p, got_bytes.size(), pc[p]);
         end
         for (int i = 0; i < pc[p] && i < got_bytes.size(); i++) begin
            vectors++;
            if (got_bytes[i] != pe[p][i]) begin
               miscompares++;
               $display("FAIL pat%0d_byte%0d: got %h, required %h", p, i, got_bytes[i], pe[p][i]);
            end
         end
         nl = 0; lp = -1;
         foreach (got_last[i]) if (got_last[i]) begin nl++; lp = i; end
         vectors++;
         if (nl != 1 || lp != pc[p] - 1) begin
            miscompares++;
            $display("FAIL pat%0d_last: last count=%0d at %0d, required 1 at %0d", p, nl, lp, pc[p] - 1);
         end
         vectors++;
         if (done_count != pc[p] || done_cyc != last_cyc + 1) begin
            miscompares++;
            $display("FAIL pat%0d_done: count=%0d done_cyc=%0d, required count=%0d done_cyc=%0d",
                     p, done_count, done_cyc, pc[p], last_cyc + 1);
         end
         vectors++;
         if ({s4_err_carry_first, s4_err_run_overflow, s4_err_carry_wrap} !== 3'b000) begin
            miscompares++;
            $display("FAIL pat%0d_errs: errs=%b, required 000", p,
                     {s4_err_carry_first, s4_err_run_overflow, s4_err_carry_wrap});
         end
      end
   endtask

   task automatic test_stall();
      int t;
      int ok;
      int exp[3];
      exp = '{8'h12, 8'h34, 8'h56};
      s4_out_ready = 1'b0;
      add_bundle(9'h012, 9'h034, 9'h056, 9'h000, 3);
      fork
         run_stream();
         begin
            t = 0;
            while (t < 100) begin
               @(negedge s4_clk);
               if (s4_out_valid) break;
               t++;
            end
            for (int i = 0; i < 5; i++) begin
               if (i > 0) @(negedge s4_clk);
               vectors++;
               if (s4_out_byte !== 8'h12 || s4_out_valid !== 1'b1 || s4_in_ready !== 1'b0) begin
                  miscompares++;
                  $display("FAIL stall_hold%0d: valid=%b byte=%h in_ready=%b, required 1 12 0",
                           i, s4_out_valid, s4_out_byte, s4_in_ready);
               end
            end
            @(posedge s4_clk);
            #1;
            s4_out_ready = 1'b1;
         end
      join
      ok = (got_bytes.size() == 3) ? 1 : 0;
      for (int i = 0; i < 3 && ok == 1; i++) if (got_bytes[i] != exp[i]) ok = 0;
      vectors++;
      if (ok != 1) begin
         miscompares++;
         $display("FAIL stall_stream: got %0d bytes (first %h), required 12 34 56",
                  got_bytes.size(), (got_bytes.size() > 0) ? got_bytes[0] : -1);
      end
      vectors++;
      if (hold_viol != 0 || done_count != 3) begin
         miscompares++;
         $display("FAIL stall_hold_count: hold violations=%0d count=%0d, required 0 and 3", hold_viol, done_count);
      end
   endtask

   task automatic test_overflow();
      int exp[5];
      int ok;
      exp = '{8'h10, 8'hFF, 8'hFF, 8'hFF, 8'h30};
      s4_out_ready = 1'b1;
      add_bundle(9'h010, 9'h0FF, 9'h0FF, 9'h0FF, 4);
      add_bundle(9'h0FF, 9'h030, 9'h000, 9'h000, 2);
      run_stream();
      ok = (got_bytes.size() == 5) ? 1 : 0;
      for (int i = 0; i < 5 && ok == 1; i++) if (got_bytes[i] != exp[i]) ok = 0;
      vectors++;
      if (ok != 1 || got_last[got_bytes.size() - 1] != 1'b1) begin
         miscompares++;
         $display("FAIL ovf_stream: got %0d bytes, required 10 FF FF FF 30 with last", got_bytes.size());
      end
      vectors++;
      if (s4_err_run_overflow !== 1'b1 || s4_err_run_overflow !== m_ov) begin
         miscompares++;
         $display("FAIL ovf_flag: err_run_overflow=%b, required 1", s4_err_run_overflow);
      end
      add_bundle(9'h012, 9'h034, 9'h056, 9'h000, 3);
      run_stream();
      vectors++;
      if (s4_err_run_overflow !== 1'b1 || done_count != 3) begin
         miscompares++;
         $display("FAIL ovf_sticky: err_run_overflow=%b count=%0d, required 1 and 3",
                  s4_err_run_overflow, done_count);
      end
   endtask

   task automatic test_carry_first_reset();
      s4_out_ready = 1'b0;
      send_bundle({9'h110, 9'h0FF, 9'h0FF, 9'h105}, 4, 1'b1);
      repeat (8) @(negedge s4_clk);
      vectors++;
      if (s4_err_carry_first !== 1'b1 || s4_out_valid !== 1'b1 || s4_out_byte !== 8'h06) begin
         miscompares++;
         $display("FAIL cf_flag: err_carry_first=%b valid=%b byte=%h, required 1 1 06",
                  s4_err_carry_first, s4_out_valid, s4_out_byte);
      end
      @(posedge s4_clk);
      #3;
      s4_reset_n = 1'b0;
      #1;
      vectors++;
      if (s4_out_valid !== 1'b0 || s4_in_ready !== 1'b0 ||
          {s4_err_carry_first, s4_err_run_overflow, s4_err_carry_wrap} !== 3'b000) begin
         miscompares++;
         $display("FAIL midrun_reset: valid=%b in_ready=%b errs=%b, required 0 0 000", s4_out_valid,
                  s4_in_ready, {s4_err_carry_first, s4_err_run_overflow, s4_err_carry_wrap});
      end
      @(posedge s4_clk);
      #1;
      s4_reset_n   = 1'b1;
      s4_out_ready = 1'b1;
      m_cf = 0; m_ov = 0; m_wrap = 0;
      clear_mon();
      repeat (4) @(posedge s4_clk);
      #1;
      vectors++;
      if (got_bytes.size() != 0) begin
         miscompares++;
         $display("FAIL reset_residue: got %0d bytes after release, required 0", got_bytes.size());
      end
      add_bundle(9'h012, 9'h034, 9'h056, 9'h000, 3);
      run_stream();
      vectors++;
      if (got_bytes.size() != 3 || got_bytes[0] != 8'h12 || got_bytes[1] != 8'h34 ||
          got_bytes[2] != 8'h56 || done_count != 3) begin
         miscompares++;
         $display("FAIL post_reset_stream: got %0d bytes count=%0d, required 12 34 56 count 3",
                  got_bytes.size(), done_count);
      end
      vectors++;
      if ({s4_err_carry_first, s4_err_run_overflow, s4_err_carry_wrap} !== 3'b000) begin
         miscompares++;
         $display("FAIL post_reset_errs: errs=%b, required 000",
                  {s4_err_carry_first, s4_err_run_overflow, s4_err_carry_wrap});
      end
   endtask

   task automatic test_random();
      int nb;
      int nl;
      int lp;
      int bad;
      bp_mode = 1'b1;
      for (int s = 0; s < 25; s++) begin
         nb = $urandom_range(1, 3);
         for (int b = 0; b < nb; b++)
            add_bundle(rand_word(), rand_word(), rand_word(), rand_word(), $urandom_range(0, LANES));
         run_stream();
         vectors++;
         if (got_bytes.size() != exp_bytes.size()) begin
            miscompares++;
            $display("FAIL rand%0d_len: got %0d bytes, required %0d", s, got_bytes.size(), exp_bytes.size());
         end
         bad = -1;
         for (int i = 0; i < exp_bytes.size() && i < got_bytes.size(); i++)
            if (bad < 0 && got_bytes[i] != exp_bytes[i]) bad = i;
         vectors++;
         if (bad >= 0) begin
            miscompares++;
            $display("FAIL rand%0d_byte%0d: got %h, required %h", s, bad, got_bytes[bad], exp_bytes[bad]);
         end
         nl = 0; lp = -1;
         foreach (got_last[i]) if (got_last[i]) begin nl++; lp = i; end
         vectors++;
         if (nl != ((exp_bytes.size() > 0) ? 1 : 0) || lp != exp_bytes.size() - 1) begin
            miscompares++;
            $display("FAIL rand%0d_last: last count=%0d at %0d, required at %0d", s, nl, lp, exp_bytes.size() - 1);
         end
         vectors++;
         if (done_count != exp_bytes.size() ||
             (exp_bytes.size() > 0 && done_cyc != last_cyc + 1) || hold_viol != 0) begin
            miscompares++;
            $display("FAIL rand%0d_done: count=%0d done_cyc=%0d holdviol=%0d, required %0d %0d 0",
                     s, done_count, done_cyc, hold_viol, exp_bytes.size(), last_cyc + 1);
         end
         vectors++;
         if ({s4_err_carry_first, s4_err_run_overflow, s4_err_carry_wrap} !== {m_cf, m_ov, m_wrap}) begin
            miscompares++;
            $display("FAIL rand%0d_errs: errs=%b, required %b", s,
                     {s4_err_carry_first, s4_err_run_overflow, s4_err_carry_wrap}, {m_cf, m_ov, m_wrap});
         end
      end
      bp_mode = 1'b0;
      @(posedge s4_clk);
      #1;
      s4_out_ready = 1'b1;
   endtask

   initial begin
      test_reset();
      test_patterns();
      test_stall();
      test_overflow();
      test_carry_first_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
